// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// State encoding, frame constants and bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } state_t;

    // 8N1 frame: start bit, 8 data bits, stop bit
    localparam int FRAME_BITS = 10;

    function automatic int bit_cycles(input int clk_hz, input int bps);
        return clk_hz / bps;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first masked request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int          j;
    logic [IW-1:0] sel;
    logic        found;

    // Scan from ptr upward and keep the first eligible index
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            sel = IW'(j);
            if (!found && req[sel] && mask[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmitter.
// Packet lock, stop-bit guard gap and frame watchdog.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int UART_BPS       = 9600,
    parameter int CLK            = 50_000_000,
    parameter int GAP_CYCLES     = bit_cycles(CLK, UART_BPS),
    parameter int TIMEOUT_CYCLES = 12 * CLK / UART_BPS
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int MAXC = (GAP_CYCLES > TIMEOUT_CYCLES) ?
                          GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    lock_id;
    logic             lock;
    logic [CNT_W-1:0] cnt;

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      win_idx;
    logic [7:0]         win_data;
    logic               accept;

    function automatic logic [IW-1:0] inc_id(input logic [IW-1:0] i);
        if (int'(i) == NUM_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    assign mask = lock ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << lock_id)
                       : '1;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req  (req_valid),
        .mask (mask),
        .ptr  (rr_ptr),
        .gnt  (gnt),
        .idx  (win_idx)
    );

    assign req_ready = (rstn && state == IDLE) ? gnt : '0;
    assign accept    = |(req_valid & req_ready);

    // Select the winning requester's byte
    always_comb begin
        win_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_data = req_data[8*i +: 8];
            end
        end
    end

    // Scheduler FSM with registered transmitter-side outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            rr_ptr      <= '0;
            lock        <= 1'b0;
            lock_id     <= '0;
            cnt         <= '0;
        end else begin
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        tx_data  <= win_data;
                        grant_id <= win_idx;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                        if (req_last[win_idx]) begin
                            lock   <= 1'b0;
                            rr_ptr <= inc_id(win_idx);
                        end else begin
                            lock    <= 1'b1;
                            lock_id <= win_idx;
                        end
                    end
                end
                START: begin
                    cnt   <= CNT_W'(TIMEOUT_CYCLES - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        cnt   <= CNT_W'(GAP_CYCLES - 1);
                        state <= GAP;
                    end else if (cnt <= CNT_W'(1)) begin
                        err_timeout <= 1'b1;
                        lock        <= 1'b0;
                        rr_ptr      <= inc_id(grant_id);
                        cnt         <= CNT_W'(GAP_CYCLES - 1);
                        state       <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a transmitter model.
// Checks grant order, timing, lock, watchdog and reset.
module tb_uart_tx_sched;

    localparam int NR = 4;
    localparam int HN = 8192;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done;
    logic              busy;
    logic [1:0]        grant_id;
    logic              err_timeout;

    logic model_done = 1'b0;
    logic stray = 1'b0;
    logic suppress = 1'b0;
    int   tx_delay = 20;
    int   mcnt = 0;

    assign tx_done = model_done | stray;

    int total = 0;
    int bad = 0;

    logic [8:0] qm [NR][32];
    int qh [NR];
    int qt [NR];
    logic [NR-1:0] fire;

    int cyc = 0;
    int ns = 0;
    int nd = 0;
    int ne = 0;
    int er_cyc = 0;
    int acc_cyc = 0;
    int rdy0 = 0;
    int multi = 0;
    int st_cyc [64];
    logic [1:0] st_id [64];
    logic [7:0] st_dat [64];
    int dn_cyc [64];
    logic [7:0] dn_dat;
    logic busy_h [HN];

    int b, db, ne0, d;
    logic [1:0] exp_id [5];
    logic [7:0] exp_dat [5];

    uart_tx_sched #(
        .NUM_REQ        (NR),
        .UART_BPS       (9600),
        .CLK            (50_000_000),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (40)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic push(input int r, input logic [7:0] dv,
                        input logic lv);
        qm[r][qt[r] % 32] = {lv, dv};
        qt[r]++;
    endtask

    task automatic flush(input int r);
        qh[r] = qt[r];
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cycles(2);
        rstn = 1'b1;
        cycles(1);
    endtask

    task automatic wait_start(input int target, input int budget);
        int k;
        k = 0;
        while (ns < target && k < budget) begin
            cycles(1);
            k++;
        end
        if (k >= budget) chk("wait_start", ns, target);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while ((ns < target || busy) && k < budget) begin
            cycles(1);
            k++;
        end
        if (k >= budget) begin
            chk("wait_starts", ns, target);
            chk("wait_idle", busy, 0);
        end
    endtask

    // Requesters: present queue heads, pop on handshake
    initial begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            qh[i] = 0;
            qt[i] = 0;
        end
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (fire[i]) qh[i]++;
                if (qh[i] < qt[i]) begin
                    req_valid[i]      = 1'b1;
                    req_last[i]       = qm[i][qh[i] % 32][8];
                    req_data[8*i +: 8] = qm[i][qh[i] % 32][7:0];
                end else begin
                    req_valid[i]      = 1'b0;
                    req_last[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                end
            end
        end
    end

    // Transmitter model: tx_done tx_delay cycles after tx_start
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0 && !suppress) model_done = 1'b1;
            end
            if (tx_start) mcnt = tx_delay;
        end
    end

    // Monitor: log starts, dones, errors and busy history
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (cyc < HN) busy_h[cyc] = busy;
            if (tx_start) begin
                st_cyc[ns % 64] = cyc;
                st_id[ns % 64]  = grant_id;
                st_dat[ns % 64] = tx_data;
                ns++;
            end
            if (tx_done) begin
                dn_cyc[nd % 64] = cyc;
                dn_dat = tx_data;
                nd++;
            end
            if (err_timeout) begin
                er_cyc = cyc;
                ne++;
            end
            if (req_ready[0]) rdy0++;
            if (|(req_valid & req_ready)) acc_cyc = cyc;
            if ((req_ready & (req_ready - 1'b1)) != '0) multi++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=done", cyc);
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        cycles(3);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_err", err_timeout, 0);
        rstn = 1'b1;
        cycles(2);

        // single byte from req0
        b = ns;
        rdy0 = 0;
        push(0, 8'hA5, 1'b1);
        wait_done(b + 1, 200);
        cycles(3);
        chk("t1_nstart", ns - b, 1);
        chk("t1_id", st_id[b % 64], 0);
        chk("t1_data", st_dat[b % 64], 8'hA5);
        chk("t1_ready_cyc", rdy0, 1);
        chk("t1_latency", st_cyc[b % 64] - acc_cyc, 1);
        chk("t1_hold_done", dn_dat, 8'hA5);
        d = dn_cyc[(nd - 1) % 64];
        chk("t1_busy_gap", busy_h[(d + 4) % HN], 1);
        chk("t1_busy_off", busy_h[(d + 6) % HN], 0);
        chk("t1_hold_idle", tx_data, 8'hA5);

        // round robin over all requesters
        do_reset();
        b = ns;
        db = nd;
        multi = 0;
        push(0, 8'h10, 1'b1);
        push(1, 8'h11, 1'b1);
        push(2, 8'h12, 1'b1);
        push(3, 8'h13, 1'b1);
        push(0, 8'h20, 1'b1);
        wait_done(b + 5, 400);
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
        chk("t2_nstart", ns - b, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_id", st_id[(b + i) % 64], exp_id[i]);
            chk("t2_data", st_dat[(b + i) % 64], exp_dat[i]);
        end
        for (int i = 0; i < 4; i++) begin
            chk("t2_gap",
                st_cyc[(b + i + 1) % 64] - dn_cyc[(db + i) % 64], 6);
        end
        chk("t2_onehot", multi, 0);

        // packet lock: req1 holds grant against req0 and req2
        do_reset();
        b = ns;
        db = nd;
        push(1, 8'hB0, 1'b0);
        push(1, 8'hB1, 1'b0);
        push(1, 8'hB2, 1'b1);
        wait_start(b + 1, 50);
        push(0, 8'hC0, 1'b1);
        push(2, 8'hC2, 1'b1);
        wait_done(b + 5, 400);
        exp_id  = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
        exp_dat = '{8'hB0, 8'hB1, 8'hB2, 8'hC2, 8'hC0};
        chk("t3_nstart", ns - b, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t3_id", st_id[(b + i) % 64], exp_id[i]);
            chk("t3_data", st_dat[(b + i) % 64], exp_dat[i]);
        end
        for (int i = 0; i < 2; i++) begin
            chk("t3_gap",
                st_cyc[(b + i + 1) % 64] - dn_cyc[(db + i) % 64], 6);
        end

        // watchdog: suppressed tx_done on a locked byte from req2
        b = ns;
        ne0 = ne;
        suppress = 1'b1;
        push(2, 8'hD0, 1'b0);
        wait_start(b + 1, 50);
        push(1, 8'hE1, 1'b1);
        push(3, 8'hE3, 1'b1);
        for (int k = 0; k < 100 && ne == ne0; k++) cycles(1);
        suppress = 1'b0;
        wait_done(b + 3, 400);
        chk("t4_nerr", ne - ne0, 1);
        chk("t4_err_time", er_cyc - st_cyc[b % 64], 40);
        chk("t4_after_err", st_cyc[(b + 1) % 64] - er_cyc, 5);
        chk("t4_id0", st_id[b % 64], 2);
        chk("t4_id1", st_id[(b + 1) % 64], 3);
        chk("t4_id2", st_id[(b + 2) % 64], 1);

        // lock held with owner idle, then reset mid-WAIT
        do_reset();
        b = ns;
        push(0, 8'hF0, 1'b0);
        wait_done(b + 1, 200);
        push(1, 8'hF1, 1'b1);
        cycles(60);
        chk("t5_locked_n", ns - b, 1);
        chk("t5_locked_busy", busy, 0);
        chk("t5_locked_rdy", req_ready, 0);
        push(0, 8'hF2, 1'b0);
        wait_start(b + 2, 50);
        cycles(10);
        chk("t5_pre_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_start", tx_start, 0);
        chk("t5_rst_data", tx_data, 0);
        chk("t5_rst_ready", req_ready, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_gid", grant_id, 0);
        chk("t5_rst_err", err_timeout, 0);
        flush(0);
        flush(1);
        cycles(2);
        rstn = 1'b1;
        b = ns;
        cycles(40);
        chk("t5_no_start", ns - b, 0);
        chk("t5_stray_busy", busy, 0);
        push(1, 8'h71, 1'b1);
        wait_done(b + 1, 200);
        chk("t5_new_id", st_id[b % 64], 1);
        chk("t5_new_data", st_dat[b % 64], 8'h71);

        // tx_done on the expiry cycle wins over the watchdog
        b = ns;
        db = nd;
        ne0 = ne;
        tx_delay = 39;
        push(2, 8'h82, 1'b1);
        push(3, 8'h83, 1'b1);
        wait_start(b + 1, 50);
        tx_delay = 20;
        wait_done(b + 2, 400);
        chk("t6_no_err", ne - ne0, 0);
        chk("t6_gap",
            st_cyc[(b + 1) % 64] - dn_cyc[db % 64], 6);
        chk("t6_id0", st_id[b % 64], 2);
        chk("t6_id1", st_id[(b + 1) % 64], 3);

        // stray tx_done while idle
        b = ns;
        stray = 1'b1;
        cycles(1);
        stray = 1'b0;
        cycles(4);
        chk("t7_stray_start", ns - b, 0);
        chk("t7_stray_busy", busy, 0);
        chk("t7_stray_err", err_timeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
